// File: rtl/regfile_pkg.sv
// Shared register-file constants and address type.
// Reused by the CPU top for instruction-field decode.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_XP_IDX   = 30;
  localparam int RF_ZERO_IDX = 31;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_sb_pend.sv
// Pending-write scoreboard: one bit per register.
// A set and a clear on the same register in one cycle leave the bit set.
module pend_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_IDX = RF_ZERO_IDX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr,
  input  logic [ADDR_W-1:0]    clr_addr,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [ADDR_W-1:0]    addr_b,
  output logic                 hit_a,
  output logic                 hit_b,
  output logic [2**ADDR_W-1:0] pend
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);

  logic [N-1:0] nxt;

  // Set is applied after clear so a new producer supersedes the old one.
  always_comb begin
    nxt = pend;
    if (clr) nxt[clr_addr] = 1'b0;
    if (set) nxt[set_addr] = 1'b1;
    nxt[ZA] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= nxt;
  end

  assign hit_a = pend[addr_a];
  assign hit_b = pend[addr_b];

endmodule

// File: rtl/regfile_sb.sv
// Three-address register file with write bypass, zero register
// and a pending-write scoreboard driving the decode stall.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int XP_IDX   = RF_XP_IDX,
  parameter int ZERO_IDX = RF_ZERO_IDX,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    ra_i,
  input  logic [ADDR_W-1:0]    rb_i,
  input  logic [ADDR_W-1:0]    rc_i,
  input  logic                 ra2sel_i,
  input  logic                 wasel_i,
  input  logic                 werf_i,
  input  logic [DATA_W-1:0]    wd_i,
  input  logic                 pend_set_i,
  input  logic [ADDR_W-1:0]    pend_addr_i,
  output logic [DATA_W-1:0]    rd1_o,
  output logic [DATA_W-1:0]    rd2_o,
  output logic                 hazard_o,
  output logic [2**ADDR_W-1:0] pend_o
);

  localparam int N = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] XA = ADDR_W'(XP_IDX);
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);
  localparam bit BYP = (BYPASS != 0);

  logic [DATA_W-1:0] regs [N];
  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] a2;
  logic              wr;
  logic              we;
  logic              res1;
  logic              res2;
  logic              pa;
  logic              pb;

  assign wa = wasel_i ? XA : rc_i;
  assign a2 = ra2sel_i ? rc_i : rb_i;
  assign wr = werf_i & rst_n;
  assign we = wr & (wa != ZA);

  assign res1 = BYP & wr & (wa == ra_i);
  assign res2 = BYP & wr & (wa == a2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    if (rst_n && ra_i != ZA) rd1_o = res1 ? wd_i : regs[ra_i];
    if (rst_n && a2 != ZA)   rd2_o = res2 ? wd_i : regs[a2];
  end

  pend_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_IDX (ZERO_IDX)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (pend_set_i),
    .set_addr (pend_addr_i),
    .clr      (wr),
    .clr_addr (wa),
    .addr_a   (ra_i),
    .addr_b   (a2),
    .hit_a    (pa),
    .hit_b    (pb),
    .pend     (pend_o)
  );

  assign hazard_o = rst_n & ((pa & ~res1) | (pb & ~res2));

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised three-address register file with write-to-read bypass, a hardwired zero register, a reset-cleared array and a pending-write scoreboard. It sits in the decode stage between the instruction fields (Ra/Rb/Rc) and the ALU operand muxes. It replaces the fixed 32×32 register file wrapper. Decode issues multi-cycle producers (loads) into the scoreboard and stalls on `hazard_o` until writeback clears the entry.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: register address width; register count is 2**ADDR_W.
- `XP_IDX`, 30: exception-pointer register index, used as the write address when `wasel_i`=1.
- `ZERO_IDX`, 31: hardwired-zero register index.
- `BYPASS`, 1: 1 = same-cycle write data is forwarded to the read ports; 0 = reads return array contents only.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ra_i`  in  ADDR_W  read address, port 1.
- `rb_i`  in  ADDR_W  read address, port 2 when `ra2sel_i`=0.
- `rc_i`  in  ADDR_W  write address; also the read address for port 2 when `ra2sel_i`=1.
- `ra2sel_i`  in  1  port-2 address select (0 = `rb_i`, 1 = `rc_i`).
- `wasel_i`  in  1  write-address select (0 = `rc_i`, 1 = `XP_IDX`).
- `werf_i`  in  1  write enable.
- `wd_i`  in  DATA_W  write data.
- `pend_set_i`  in  1  marks a register as pending (a producer has been issued).
- `pend_addr_i`  in  ADDR_W  register to mark pending.
- `rd1_o`  out  DATA_W  read data, port 1.
- `rd2_o`  out  DATA_W  read data, port 2.
- `hazard_o`  out  1  a read operand is pending and not resolved this cycle.
- `pend_o`  out  2**ADDR_W  scoreboard bit vector, for debug and bench observation.

## Operation
- Write address: wa = `wasel_i` ? `XP_IDX` : `rc_i`. Port-2 address: a2 = `ra2sel_i` ? `rc_i` : `rb_i`.
- Write: when `werf_i`=1 and wa≠`ZERO_IDX`, reg[wa] ← `wd_i` at the clock edge. Writes to `ZERO_IDX` are dropped.
- Read, combinational for each port with address a:
  - a=`ZERO_IDX` → 0;
  - else if `BYPASS` and `werf_i` and wa=a → `wd_i`;
  - else reg[a].
- Scoreboard, one bit per register:
  - set on `pend_set_i` for `pend_addr_i`;
  - cleared when `werf_i` writes that address.
  - If set and clear hit the same register in one cycle, set wins (a new producer supersedes the completing one).
  - Set to `ZERO_IDX` is ignored; `pend_o[ZERO_IDX]` is always 0.
- Hazard: `hazard_o` = (pend[ra] ∧ ¬res(ra)) ∨ (pend[a2] ∧ ¬res(a2)).
  - res(a) = `BYPASS` ∧ `werf_i` ∧ wa=a.
  - With `BYPASS`=0 the hazard holds one extra cycle, until the written value is in the array.
- Widths: addresses are compared at full ADDR_W; no truncation; data is unmodified.

## Timing
- Reset (`rst_n`=0, asynchronous): all registers ← 0 and all pend bits ← 0 immediately.
  - While `rst_n`=0: `rd1_o`=`rd2_o`=0, `hazard_o`=0, `pend_o`=0.
  - Writes and bypass are gated off during reset.
- Reset asserted mid-operation discards any in-flight pending state. Decode must re-issue.
- Read latency: 0 cycles (combinational from addresses, `werf_i`, `wd_i`).
- Write latency: data is visible in the array from the cycle after the edge. With `BYPASS`=1 it is visible in the write cycle itself.
- Scoreboard latency:
  - `pend_set_i` at edge N → `pend_o` and `hazard_o` reflect it from cycle N+1.
  - A clearing write is seen combinationally in its own cycle when `BYPASS`=1.
- No state machine beyond the array and scoreboard. No ready/valid handshake: decode holds its addresses while `hazard_o`=1.

## Structure
- Shared package `regfile_pkg`: default `DATA_W`, `ADDR_W`, `XP_IDX`, `ZERO_IDX` constants and an address typedef. The CPU top reuses these for instruction-field decode.
- Natural sub-module: `pend_scoreboard`, which holds the pend vector with set/clear priority and exposes a lookup for two addresses. The array, address muxes and bypass stay in `regfile_sb`.

## Test plan
- Reset value: hold `rst_n`=0, drive `werf_i`=1, wd=0xDEADBEEF → all reads 0, `pend_o`=0. Release reset, then read every register → 0.
- Write/read with bypass:
  - Write R5=0x12345678 with ra=5 in the same cycle → `rd1_o`=0x12345678 in that cycle (`BYPASS`=1).
  - With `BYPASS`=0, the old value (0) appears in the write cycle and 0x12345678 the next cycle.
- Zero register: write R31=0xFFFFFFFF and `pend_set_i` to 31 → reading R31 gives 0, `pend_o[31]`=0, `hazard_o`=0.
- XP and port-2 select:
  - `wasel_i`=1, rc=3, wd=0xA5A5A5A5 → R30 is written and R3 is unchanged.
  - `ra2sel_i`=1, rc=30 → `rd2_o`=0xA5A5A5A5.
- Scoreboard:
  - pend_set R7, then read rb=7 → `hazard_o`=1 next cycle.
  - Write R7=0x77 → `hazard_o`=0 in that cycle (`BYPASS`=1) with `rd2_o`=0x77; `pend_o[7]`=0 after.
  - Same-cycle set+write on R7 → `pend_o[7]`=1.
- Async reset mid-stall: with R7 pending and `hazard_o`=1, pulse `rst_n` low between edges → `hazard_o` and `pend_o` go 0 without a clock edge, and R7 reads 0.
